fetch_queue: RTL

- Parametrised instruction prefetch queue between instruction memory and the pipelined RiSC-16 core fetch stage.
- Generates sequential word-addressed fetch requests and tolerates variable in-order memory latency.
- Buffers up to p_DEPTH instruction/PC pairs and presents them to the core under a ready/valid handshake.
- Flushes on branch/JALR redirect and silently discards stale in-flight responses, replacing the lock-step single-instruction feed the core has today.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch with credit-based request throttling,
// in-order responses, redirect flush. Define FETCH_QUEUE_BYPASS_EN for same-cycle empty bypass.
module fetch_queue #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 16,
  parameter int p_DEPTH    = 4,
  parameter logic [p_ADDR_LEN-1:0] p_RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic [p_ADDR_LEN-1:0]      o_imem_addr,
  output logic                       o_imem_req,
  input  logic [p_WORD_LEN-1:0]      i_imem_data,
  input  logic                       i_imem_valid,
  output logic [p_WORD_LEN-1:0]      o_inst,
  output logic [p_ADDR_LEN-1:0]      o_inst_pc,
  output logic                       o_inst_valid,
  input  logic                       i_inst_ready,
  input  logic                       i_redirect,
  input  logic [p_ADDR_LEN-1:0]      i_redirect_pc,
  output logic [$clog2(p_DEPTH):0]   o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(p_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = CW + 1;
  localparam logic [CW-1:0] DEPTH_Q = p_DEPTH[CW-1:0];
  localparam logic [IW-1:0] DEPTH_I = p_DEPTH[IW-1:0];

  logic [p_ADDR_LEN-1:0] fetch_pc;

  logic [p_WORD_LEN-1:0] q_inst [p_DEPTH];
  logic [p_ADDR_LEN-1:0] q_pc   [p_DEPTH];
  logic [AW-1:0]         q_rd, q_wr;
  logic [CW-1:0]         count;

  logic [p_ADDR_LEN-1:0] pend_pc [p_DEPTH];
  logic [AW-1:0]         pend_rd, pend_wr;

  logic [IW-1:0] inflight, drop, live, credit;
  logic          q_empty, rsp_live, rsp_drop, bypass, bypass_take, push, pop;
  logic [p_ADDR_LEN-1:0] rsp_pc;

  // live = requests whose responses will be kept; bounded by the credit rule
  assign live   = inflight - drop;
  assign credit = live + IW'(count);

  assign o_imem_req  = i_rst && !i_redirect && (credit < DEPTH_I);
  assign o_imem_addr = fetch_pc;

  assign q_empty  = (count == '0);
  assign rsp_live = i_imem_valid && (drop == '0) && !i_redirect;
  assign rsp_drop = i_imem_valid && (drop != '0) && !i_redirect;
  assign rsp_pc   = pend_pc[pend_rd];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = i_rst && rsp_live && q_empty;
`else
  assign bypass = 1'b0;
`endif
  assign bypass_take = bypass && i_inst_ready;

  assign push = rsp_live && !bypass_take;
  assign pop  = !q_empty && i_inst_ready && !i_redirect;

  assign o_inst_valid = !q_empty || bypass;
  assign o_count      = count;
  assign o_full       = (count == DEPTH_Q);
  assign o_empty      = q_empty;

  always_comb begin
    o_inst    = '0;
    o_inst_pc = '0;
    if (!q_empty) begin
      o_inst    = q_inst[q_rd];
      o_inst_pc = q_pc[q_rd];
    end else if (bypass) begin
      o_inst    = i_imem_data;
      o_inst_pc = rsp_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_imem_req) pend_pc[pend_wr] <= fetch_pc;
    if (push) begin
      q_inst[q_wr] <= i_imem_data;
      q_pc[q_wr]   <= rsp_pc;
    end
  end

  // On redirect every outstanding PC entry is stale, so the pending-PC FIFO is
  // cleared outright; dropped responses then never touch it, which keeps it
  // p_DEPTH deep even while old responses are still draining.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fetch_pc <= p_RESET_PC;
      q_rd     <= '0;
      q_wr     <= '0;
      count    <= '0;
      pend_rd  <= '0;
      pend_wr  <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + IW'(o_imem_req) - IW'(i_imem_valid);
      if (i_redirect) begin
        fetch_pc <= i_redirect_pc;
        q_rd     <= '0;
        q_wr     <= '0;
        count    <= '0;
        pend_rd  <= '0;
        pend_wr  <= '0;
        drop     <= inflight - IW'(i_imem_valid);
      end else begin
        if (o_imem_req) begin
          fetch_pc <= fetch_pc + 1'b1;
          pend_wr  <= pend_wr + 1'b1;
        end
        if (rsp_live) pend_rd <= pend_rd + 1'b1;
        if (rsp_drop) drop <= drop - 1'b1;
        if (push) q_wr <= q_wr + 1'b1;
        if (pop)  q_rd <= q_rd + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
